avalon_pio_bank: RTL and testbench

// - Parametrised Avalon-MM PIO for the NIOS II SoC. Replaces the separate fixed-width LED, hex-digit and key PIOs.
// - Provides one output bank with atomic set/clear.
// - Provides one input bank with 2-FF sync, per-bit debounce, per-bit edge capture and a maskable level IRQ.
// - Sits on the system interconnect as a memory-mapped slave with read latency 1.

---
 rtl/avalon_pio_bank_if.sv | 33 +++
 rtl/avalon_pio_bank.sv | 181 ++++++++++++++++++
 tb/tb_avalon_pio_bank.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pio_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_bank_if
// Brief    : Avalon-MM slave bus bundle for the PIO bank (word-addressed, 32-bit).
// Revision : 1.0 - initial release
// ============================================================================
interface avalon_pio_bank_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/avalon_pio_bank.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_bank
// Brief    : Parametrised Avalon-MM PIO: output bank with atomic set/clear,
//            debounced input bank with edge capture and maskable level IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pio_bank #(
    parameter int               OUT_W        = 16,
    parameter int               IN_W         = 2,
    parameter int               DEBOUNCE_CYC = 500000,
    parameter logic [OUT_W-1:0] OUT_RESET    = '0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    avalon_pio_bank_if.slave       bus,
    output logic [OUT_W-1:0]       pio_out,
    input  wire logic [IN_W-1:0]   pio_in
);

    localparam int                 c_CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [31:0]        c_INFO    = {8'hA5, 8'(IN_W), 16'(OUT_W)};

    localparam logic [2:0] c_ADDR_OUT  = 3'd0;
    localparam logic [2:0] c_ADDR_SET  = 3'd1;
    localparam logic [2:0] c_ADDR_CLR  = 3'd2;
    localparam logic [2:0] c_ADDR_IN   = 3'd3;
    localparam logic [2:0] c_ADDR_MASK = 3'd4;
    localparam logic [2:0] c_ADDR_EDGE = 3'd5;
    localparam logic [2:0] c_ADDR_MODE = 3'd6;
    localparam logic [2:0] c_ADDR_INFO = 3'd7;

    logic [OUT_W-1:0] r_out;
    logic [IN_W-1:0]  r_mask;
    logic [IN_W-1:0]  r_mode;
    logic [IN_W-1:0]  r_edge;
    logic             r_irq;
    logic [31:0]      r_readdata;
    logic [IN_W-1:0]  r_sync1;
    logic [IN_W-1:0]  r_sync2;
    logic [IN_W-1:0]  r_deb_q;

    logic [OUT_W-1:0] w_out_next;
    logic [OUT_W-1:0] w_wd_out;
    logic [IN_W-1:0]  w_wd_in;
    logic [IN_W-1:0]  w_deb;
    logic [IN_W-1:0]  w_rise;
    logic [IN_W-1:0]  w_fall;
    logic [IN_W-1:0]  w_event;
    logic [IN_W-1:0]  w_w1c;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wd;

    assign w_wd_out    = bus.writedata[OUT_W-1:0];
    assign w_wd_in     = bus.writedata[IN_W-1:0];
    assign w_unused_wd = &{1'b0, bus.writedata};

    // ------------------------------------------------------------------
    // Output bank
    // ------------------------------------------------------------------
    always_comb begin
        w_out_next = r_out;
        if (bus.write) begin
            case (bus.address)
                c_ADDR_OUT: w_out_next = w_wd_out;
                c_ADDR_SET: w_out_next = r_out | w_wd_out;
                c_ADDR_CLR: w_out_next = r_out & ~w_wd_out;
                default:    w_out_next = r_out;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= OUT_RESET;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign pio_out = r_out;

    // ------------------------------------------------------------------
    // Input synchroniser and per-bit debounce
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_q <= '0;
        end else begin
            r_sync1 <= pio_in;
            r_sync2 <= r_sync1;
            r_deb_q <= w_deb;
        end
    end

    generate
        for (genvar gi = 0; gi < IN_W; gi++) begin : g_deb
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_deb;

            // Any sample that agrees with the current level restarts qualification.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2[gi] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_deb <= r_sync2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge capture, control registers and IRQ
    // ------------------------------------------------------------------
    assign w_rise  = w_deb & ~r_deb_q;
    assign w_fall  = ~w_deb & r_deb_q;
    assign w_event = (r_mode & w_rise) | (~r_mode & w_fall);
    assign w_w1c   = (bus.write && (bus.address == c_ADDR_EDGE)) ? w_wd_in : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            r_mode <= '0;
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (bus.write && (bus.address == c_ADDR_MASK)) begin
                r_mask <= w_wd_in;
            end
            if (bus.write && (bus.address == c_ADDR_MODE)) begin
                r_mode <= w_wd_in;
            end
            // A new event on the same cycle as its clear keeps the bit set.
            r_edge <= (r_edge & ~w_w1c) | w_event;
            r_irq  <= |(r_edge & r_mask);
        end
    end

    assign bus.irq = r_irq;

    // ------------------------------------------------------------------
    // Read path: registered, sampled from pre-write register state
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            c_ADDR_OUT,
            c_ADDR_SET,
            c_ADDR_CLR:  w_rd_mux[OUT_W-1:0] = r_out;
            c_ADDR_IN:   w_rd_mux[IN_W-1:0]  = w_deb;
            c_ADDR_MASK: w_rd_mux[IN_W-1:0]  = r_mask;
            c_ADDR_EDGE: w_rd_mux[IN_W-1:0]  = r_edge;
            c_ADDR_MODE: w_rd_mux[IN_W-1:0]  = r_mode;
            c_ADDR_INFO: w_rd_mux            = c_INFO;
            default:     w_rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (bus.read) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_pio_bank
// Brief    : Directed and randomised bench for avalon_pio_bank against a
//            behavioural register/input model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_pio_bank;
    localparam int               OUT_W   = 16;
    localparam int               IN_W    = 2;
    localparam int               DEB     = 4;
    localparam logic [OUT_W-1:0] RST_OUT = 16'h00F0;

    logic             clk = 1'b0;
    logic             reset;
    logic [OUT_W-1:0] pio_out;
    logic [IN_W-1:0]  pio_in;
    int               checks = 0;
    int               errors = 0;

    avalon_pio_bank_if bus ();

    avalon_pio_bank #(
        .OUT_W       (OUT_W),
        .IN_W        (IN_W),
        .DEBOUNCE_CYC(DEB),
        .OUT_RESET   (RST_OUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .pio_out(pio_out),
        .pio_in (pio_in)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [OUT_W-1:0] m_out;
    logic [IN_W-1:0]  m_mask, m_mode, m_edge, m_s1, m_s2, m_deb, m_debq;
    logic             m_irq;
    logic [31:0]      m_rd;
    logic [IN_W-1:0]  m_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = RST_OUT;
        m_mask = '0;
        m_mode = '0;
        m_edge = '0;
        m_s1   = '0;
        m_s2   = '0;
        m_deb  = '0;
        m_debq = '0;
        m_irq  = 1'b0;
        m_rd   = '0;
        m_hist.delete();
    endtask

    function automatic logic [31:0] reg_value(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2: return 32'(m_out);
            3'd3:             return 32'(m_deb);
            3'd4:             return 32'(m_mask);
            3'd5:             return 32'(m_edge);
            3'd6:             return 32'(m_mode);
            default:          return {8'hA5, 8'(IN_W), 16'(OUT_W)};
        endcase
    endfunction

    // One clock edge of the model, using the inputs presented at that edge.
    task automatic model_step();
        logic [IN_W-1:0]  deb_n, rise, fall, ev, w1c, wd;
        logic [OUT_W-1:0] wo;
        logic             all_diff;
        wd = bus.writedata[IN_W-1:0];
        wo = bus.writedata[OUT_W-1:0];
        if (bus.read) m_rd = reg_value(bus.address);
        // A level is accepted once the last DEB synced samples all disagree with it.
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        deb_n = m_deb;
        if (m_hist.size() == DEB) begin
            for (int b = 0; b < IN_W; b++) begin
                all_diff = 1'b1;
                foreach (m_hist[k]) if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) deb_n[b] = ~m_deb[b];
            end
        end
        rise  = m_deb & ~m_debq;
        fall  = ~m_deb & m_debq;
        ev    = (m_mode & rise) | (~m_mode & fall);
        w1c   = (bus.write && bus.address == 3'd5) ? wd : '0;
        m_irq = |(m_edge & m_mask);
        m_edge = (m_edge & ~w1c) | ev;
        if (bus.write) begin
            case (bus.address)
                3'd0: m_out = wo;
                3'd1: m_out = m_out | wo;
                3'd2: m_out = m_out & ~wo;
                3'd4: m_mask = wd;
                3'd6: m_mode = wd;
                default: ;
            endcase
        end
        m_debq = m_deb;
        m_deb  = deb_n;
        m_s2   = m_s1;
        m_s1   = pio_in;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pio_out", 32'(pio_out), 32'(m_out));
        check("irq", 32'(bus.irq), 32'(m_irq));
        check("readdata", bus.readdata, m_rd);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.write = 1'b1; bus.address = a; bus.writedata = d;
        cycle();
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.read = 1'b1; bus.address = a;
        cycle();
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          hold[IN_W];
        reset = 1'b1; pio_in = '0;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and ID register
        check("rst_pio_out", 32'(pio_out), 32'h0000_00F0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        rd(3'd3, d); check("rst_in", d, 32'h0);
        rd(3'd4, d); check("rst_mask", d, 32'h0);
        rd(3'd5, d); check("rst_edge", d, 32'h0);
        rd(3'd6, d); check("rst_mode", d, 32'h0);
        rd(3'd7, d); check("info", d, 32'hA502_0010);

        // Output write / set / clear
        wr(3'd0, 32'hFFFF_1234); check("out_wr", 32'(pio_out), 32'h1234);
        wr(3'd1, 32'h0000_000F); check("out_set", 32'(pio_out), 32'h123F);
        wr(3'd2, 32'h0000_0230); check("out_clr", 32'(pio_out), 32'h100F);
        rd(3'd1, d); check("set_rd", d, 32'h100F);

        // Short glitch is rejected
        pio_in[0] = 1'b1; idle(3);
        pio_in[0] = 1'b0; idle(8);
        rd(3'd3, d); check("glitch_in", d, 32'h0);

        // Held input qualifies exactly 6 cycles after the pin edge
        pio_in[0] = 1'b1; idle(5);
        rd(3'd3, d); check("deb_cyc6_old", d, 32'h0);
        rd(3'd3, d); check("deb_cyc7", d, 32'h1);

        // Rising capture and IRQ, then W1C
        wr(3'd6, 32'h3); wr(3'd4, 32'h3);
        pio_in[0] = 1'b0; idle(8);
        rd(3'd5, d); check("fall_not_captured", d, 32'h0);
        pio_in[0] = 1'b1; idle(7);
        check("irq_before", 32'(bus.irq), 32'h0);
        rd(3'd5, d); check("edge_set", d, 32'h1);
        check("irq_set", 32'(bus.irq), 32'h1);
        wr(3'd5, 32'h1);
        rd(3'd5, d); check("edge_cleared", d, 32'h0);
        check("irq_cleared", 32'(bus.irq), 32'h0);

        // W1C colliding with a new event on input 1: set wins
        pio_in[1] = 1'b1; idle(7);
        pio_in[1] = 1'b0; idle(8);
        pio_in[1] = 1'b1; idle(6);
        wr(3'd5, 32'h2);
        rd(3'd5, d); check("edge_collide", d, 32'h2);
        check("irq_collide", 32'(bus.irq), 32'h1);

        // Reset mid-count with pins held high
        pio_in[0] = 1'b0; idle(8);
        pio_in[0] = 1'b1; idle(3);
        do_reset();
        check("rst2_pio_out", 32'(pio_out), 32'h0000_00F0);
        check("rst2_irq", 32'(bus.irq), 32'h0);
        wr(3'd6, 32'h1); idle(4);
        rd(3'd3, d); check("rst2_deb_low", d, 32'h0);
        rd(3'd3, d); check("rst2_deb_high", d, 32'h3);
        rd(3'd5, d); check("rst2_edge", d, 32'h1);

        // Randomised traffic against the model
        for (int b = 0; b < IN_W; b++) hold[b] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < IN_W; b++) begin
                if (hold[b] == 0) begin
                    pio_in[b] = ~pio_in[b];
                    hold[b]   = $urandom_range(1, 9);
                end else begin
                    hold[b]--;
                end
            end
            bus.address   = 3'($urandom_range(0, 7));
            bus.writedata = $urandom;
            bus.write     = ($urandom_range(0, 3) == 0);
            bus.read      = ($urandom_range(0, 1) == 0);
            cycle();
        end
        bus.write = 1'b0;
        bus.read  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
